fp_divider: RTL

- Sequential IEEE-754 single-precision divider; computes p = a / b.
- Counterpart to the team's FP32 multiplier and uses the same packed operand bus, a = data[63:32], b = data[31:0].
- Uses a radix-2 restoring mantissa divider with a start/valid handshake.
- Sits beside the multiplier in the FP datapath; results are consumed on a one-cycle valid pulse.

---
 rtl/fp_divider.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/fp_divider.sv
// rtl/fp_divider.sv - Sequential FP32 divider (restoring radix-2), p = a / b.
// Define FPDIV_RNE_EN for round-to-nearest-even; default build rounds toward zero.
module fp_divider #(
  parameter int N     = 32,
  parameter int M     = 64,
  parameter int QBITS = 27
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] data,
  output logic [N-1:0] p,
  output logic         valid,
  output logic         busy,
  output logic [3:0]   flags
);

  localparam logic [4:0]  LAST_ITER = 5'(QBITS - 1);
  localparam logic [31:0] QNAN      = 32'h7FC00000;

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_DIVIDE, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [M-1:0]      data_q;
  logic              sign;
  logic [7:0]        ea, eb;
  logic [23:0]       ma, mb;
  logic [24:0]       rem;
  logic [26:0]       q;
  logic [4:0]        cnt;
  logic [22:0]       frac;
  logic signed [9:0] e;
`ifdef FPDIV_RNE_EN
  logic              g, s;
`endif

  // Operand classification; exponent 0 is flushed to zero regardless of fraction.
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, is_special;
  logic [31:0] sp_p;
  logic [3:0]  sp_flags;

  always_comb begin
    a_zero     = (ea == 8'h00);
    b_zero     = (eb == 8'h00);
    a_inf      = (ea == 8'hFF) && (ma[22:0] == 23'h0);
    b_inf      = (eb == 8'hFF) && (mb[22:0] == 23'h0);
    a_nan      = (ea == 8'hFF) && (ma[22:0] != 23'h0);
    b_nan      = (eb == 8'hFF) && (mb[22:0] != 23'h0);
    is_special = 1'b1;
    sp_p       = 32'h0;
    sp_flags   = 4'b0000;
    if (a_nan || b_nan) begin
      sp_p     = QNAN;
      sp_flags = 4'b1000;
    end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
      sp_p     = QNAN;
      sp_flags = 4'b1000;
    end else if (a_inf) begin
      sp_p     = {sign, 8'hFF, 23'h0};
    end else if (b_zero) begin
      sp_p     = {sign, 8'hFF, 23'h0};
      sp_flags = 4'b0100;
    end else if (b_inf || a_zero) begin
      sp_p     = {sign, 31'h0};
    end else begin
      is_special = 1'b0;
    end
  end

  // One restoring step; the difference fits 24 bits whenever it is selected.
  logic        rem_ge;
  logic [23:0] rem_diff, rem_kept;

  always_comb begin
    rem_ge   = (rem >= {1'b0, mb});
    rem_diff = rem[23:0] - mb;
    rem_kept = rem_ge ? rem_diff : rem[23:0];
  end

  logic [22:0]       frac_r;
  logic signed [9:0] e_r;
  logic [31:0]       rd_p;
  logic [3:0]        rd_flags;
`ifdef FPDIV_RNE_EN
  logic [23:0]       frac_inc;
`endif

  always_comb begin
`ifdef FPDIV_RNE_EN
    frac_inc = {1'b0, frac} + {23'h0, g & (s | frac[0])};
    frac_r   = frac_inc[22:0];
    e_r      = e + $signed({9'h0, frac_inc[23]});
`else
    frac_r   = frac;
    e_r      = e;
`endif
    rd_flags = 4'b0000;
    if (e_r >= 10'sd255) begin
`ifdef FPDIV_RNE_EN
      rd_p   = {sign, 8'hFF, 23'h0};
`else
      rd_p   = {sign, 8'hFE, 23'h7FFFFF};
`endif
      rd_flags = 4'b0010;
    end else if (e_r <= 10'sd0) begin
      rd_p     = {sign, 31'h0};
      rd_flags = 4'b0001;
    end else begin
      rd_p     = {sign, e_r[7:0], frac_r};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_UNPACK;
      S_UNPACK:  state_nxt = S_SPECIAL;
      S_SPECIAL: state_nxt = is_special ? S_DONE : S_DIVIDE;
      S_DIVIDE:  if (cnt == LAST_ITER) state_nxt = S_NORM;
      S_NORM:    state_nxt = S_ROUND;
      S_ROUND:   state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    valid = (state == S_DONE);
    busy  = (state != S_IDLE);
  end

  // p/flags load on the edge entering DONE so they are stable alongside valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      sign   <= 1'b0;
      ea     <= 8'h0;
      eb     <= 8'h0;
      ma     <= 24'h0;
      mb     <= 24'h0;
      rem    <= 25'h0;
      q      <= 27'h0;
      cnt    <= 5'h0;
      frac   <= 23'h0;
      e      <= 10'sd0;
`ifdef FPDIV_RNE_EN
      g      <= 1'b0;
      s      <= 1'b0;
`endif
      p      <= '0;
      flags  <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: if (start) data_q <= data;
        S_UNPACK: begin
          sign <= data_q[63] ^ data_q[31];
          ea   <= data_q[62:55];
          eb   <= data_q[30:23];
          ma   <= {1'b1, data_q[54:32]};
          mb   <= {1'b1, data_q[22:0]};
        end
        S_SPECIAL: begin
          if (is_special) begin
            p     <= sp_p;
            flags <= sp_flags;
          end
          rem <= {1'b0, ma};
          q   <= 27'h0;
          cnt <= 5'h0;
        end
        S_DIVIDE: begin
          q   <= {q[25:0], rem_ge};
          rem <= {rem_kept, 1'b0};
          cnt <= (cnt == LAST_ITER) ? 5'h0 : cnt + 5'h1;
        end
        S_NORM: begin
          if (q[26]) begin
            frac <= q[25:3];
            e    <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
`ifdef FPDIV_RNE_EN
            g    <= q[2];
            s    <= (|q[1:0]) | (rem != 25'h0);
`endif
          end else begin
            frac <= q[24:2];
            e    <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd126;
`ifdef FPDIV_RNE_EN
            g    <= q[1];
            s    <= q[0] | (rem != 25'h0);
`endif
          end
        end
        S_ROUND: begin
          p     <= rd_p;
          flags <= rd_flags;
        end
        default: ;
      endcase
    end
  end

endmodule
